// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared register-file write-port types and constants for the write-port arbiter slice.
package regfile_wport_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wreq_t;

  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [REG_ADDR_W-1:0] addr);
    regOneHot = '0;
    regOneHot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wq_fifo.sv
// Circular write-request buffer for the long-latency port; exposes per-slot
// addresses and validity so the arbiter can build the pending-write mask.
module regfile_wq_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wreq_t                            pushReq,
  input  logic                             pop,
  output wreq_t                            headReq,
  output logic [CNT_W-1:0]                 count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entryAddr,
  output logic [DEPTH-1:0]                 entryValid
);

  wreq_t            mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush  = push && (count != CNT_W'(DEPTH));
  assign doPop   = pop && (count != '0);
  assign headReq = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushReq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + CNT_W'(1);
      else if (doPop && !doPush) count <= count - CNT_W'(1);
    end
  end

  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset     = '0;
    entryValid = '0;
    entryAddr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rdPtr;
      entryValid[i] = ({1'b0, offset} < count);
      entryAddr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between the writeback stage (A) and a
// FIFO-buffered long-latency unit (B), with a starvation override for B.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [REG_DATA_W-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [REG_DATA_W-1:0] b_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [REG_DATA_W-1:0] wr_data,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  starve_active
);

  localparam int unsigned WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  wreq_t                                aReq;
  wreq_t                                bReq;
  wreq_t                                headReq;
  wreq_t                                grantReq;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entryAddr;
  logic [FIFO_DEPTH-1:0]                entryValid;
  logic                                 fifoEmpty;
  logic                                 grantA;
  logic                                 grantB;
  logic                                 doPush;
  logic [WAIT_W-1:0]                    waitCnt;

  assign aReq = '{addr: a_addr, data: a_data};
  assign bReq = '{addr: b_addr, data: b_data};

  assign fifoEmpty     = (fifo_count == '0);
  assign starve_active = (waitCnt == WAIT_W'(STARVE_LIMIT)) && !fifoEmpty;
  assign a_ready       = !starve_active;
  assign b_ready       = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign doPush        = b_valid && b_ready;

  assign grantA   = a_valid && !starve_active;
  assign grantB   = !fifoEmpty && (starve_active || !a_valid);
  assign grantReq = grantB ? headReq : aReq;

  regfile_wq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (doPush),
    .pushReq   (bReq),
    .pop       (grantB),
    .headReq   (headReq),
    .count     (fifo_count),
    .entryAddr (entryAddr),
    .entryValid(entryValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (fifoEmpty || grantB) begin
      waitCnt <= '0;
    end else if (waitCnt != WAIT_W'(STARVE_LIMIT)) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  // Writes to the zero register still complete their handshake but never strobe wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grantA || grantB) begin
      wr_en   <= (grantReq.addr != REG_ADDR_W'(ZERO_REG));
      wr_addr <= grantReq.addr;
      wr_data <= grantReq.data;
    end else begin
      wr_en <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entryValid[i]) pending_mask = pending_mask | regOneHot(entryAddr[i]);
    end
    pending_mask[ZERO_REG] = 1'b0;
  end

endmodule
